// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard: the per-stage
// destination tag entry, forwarding-select encoding and default latencies.
package mips_pipe_pkg;

   localparam int RAW_MAX      = 8;
   localparam int RDYW         = 4;
   localparam int FWD_REGFILE  = 0;
   localparam int LOAD_LAT_DEF = 1;
   localparam int ALU_LAT_DEF  = 0;

   typedef struct packed {
      logic                valid;
      logic [RAW_MAX-1:0]  rd;
      logic                reg_write;
      logic [RDYW-1:0]     ready_stage;
      logic [RAW_MAX-1:0]  rs;
      logic [RAW_MAX-1:0]  rt;
      logic                use_rs;
      logic                use_rt;
   } stage_entry_t;

   // An entry produces a source only if it really writes a nonzero register the reader uses
   function automatic logic produces(input stage_entry_t e,
                                     input logic [RAW_MAX-1:0] src,
                                     input logic use_src);
      return e.valid && e.reg_write && use_src && (e.rd == src) && (e.rd != '0);
   endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-side bundle of the hazard scoreboard: decoded ID fields and flush in,
// hold/bubble/forward selects and the stall counter out.
interface pipe_hazard_scoreboard_if #(
   parameter int NSTAGE = 3,
   parameter int RAW    = 5,
   parameter int CNTW   = 32
) ();
   localparam int FW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   logic            id_valid;
   logic [RAW-1:0]  id_rs;
   logic [RAW-1:0]  id_rt;
   logic            id_use_rs;
   logic            id_use_rt;
   logic [RAW-1:0]  id_rd;
   logic            id_reg_write;
   logic            id_mem_read;
   logic            flush;
   logic            stall;
   logic            bubble;
   logic [FW-1:0]   fwd_a;
   logic [FW-1:0]   fwd_b;
   logic [CNTW-1:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_reg_write, id_mem_read, flush,
      input  stall, bubble, fwd_a, fwd_b, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_reg_write, id_mem_read, flush,
      output stall, bubble, fwd_a, fwd_b, stall_count
   );
endinterface

// File: rtl/pipe_hazard_scoreboard_tag_shift.sv
// Shift register of destination-tag entries, one per post-ID stage; stage 0
// takes either the ID entry or an invalid bubble.
module pipe_tag_shift
   import mips_pipe_pkg::*;
#(
   parameter int NSTAGE = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  stage_entry_t in_entry,
   output stage_entry_t entries [NSTAGE]
);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTAGE; k++) entries[k] <= '0;
      end else begin
         entries[0] <= load ? in_entry : '0;
         for (int k = 1; k < NSTAGE; k++) entries[k] <= entries[k-1];
      end
   end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Parametrised hazard detection and forwarding unit beside the ID stage:
// tracks in-flight destination tags and produces stall, bubble and forward selects.
module pipe_hazard_scoreboard
   import mips_pipe_pkg::*;
#(
   parameter int NSTAGE   = 3,
   parameter int RAW      = 5,
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int ALU_LAT  = ALU_LAT_DEF,
   parameter int FWD_EN   = 1,
   parameter int CNTW     = 32
) (
   input logic                     clk,
   input logic                     rst,
   pipe_hazard_scoreboard_if.slave bus
);

   localparam int FW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   stage_entry_t       id_entry;
   stage_entry_t       entries [NSTAGE];
   logic [RAW_MAX-1:0] id_rs_x;
   logic [RAW_MAX-1:0] id_rt_x;
   logic [NSTAGE-1:0]  hazard;
   logic [NSTAGE-1:0]  fhit_rs;
   logic [NSTAGE-1:0]  fhit_rt;
   logic               stall;
   logic               load;
   logic [FW-1:0]      fwd_a;
   logic [FW-1:0]      fwd_b;
   logic [CNTW-1:0]    count;

   assign id_rs_x = RAW_MAX'(bus.id_rs);
   assign id_rt_x = RAW_MAX'(bus.id_rt);

   always_comb begin
      id_entry             = '0;
      id_entry.valid       = bus.id_valid;
      id_entry.rd          = RAW_MAX'(bus.id_rd);
      id_entry.reg_write   = bus.id_reg_write;
      id_entry.ready_stage = bus.id_mem_read ? RDYW'(LOAD_LAT) : RDYW'(ALU_LAT);
      id_entry.rs          = id_rs_x;
      id_entry.rt          = id_rt_x;
      id_entry.use_rs      = bus.id_use_rs;
      id_entry.use_rt      = bus.id_use_rt;
   end

   assign load = bus.id_valid && !stall && !bus.flush;

   pipe_tag_shift #(.NSTAGE(NSTAGE)) u_tags (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .in_entry (id_entry),
      .entries  (entries)
   );

   // Without forwarding a producer is only safe once it sits in the last (write-back) stage
   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      logic hit;
      assign hit = produces(entries[k], id_rs_x, bus.id_use_rs)
                 | produces(entries[k], id_rt_x, bus.id_use_rt);
      if (FWD_EN != 0) begin : g_fwd
         assign hazard[k] = hit && (32'(k) < 32'(entries[k].ready_stage));
      end else begin : g_nofwd
         assign hazard[k] = hit && (k <= NSTAGE - 2);
      end
      if (k == 0) begin : g_ex
         assign fhit_rs[k] = 1'b0;
         assign fhit_rt[k] = 1'b0;
      end else begin : g_later
         assign fhit_rs[k] = produces(entries[k], entries[0].rs, entries[0].use_rs);
         assign fhit_rt[k] = produces(entries[k], entries[0].rt, entries[0].use_rt);
      end
   end

   assign stall = bus.id_valid && !bus.flush && (|hazard);

   // Scan from the oldest stage down so the youngest matching producer wins
   always_comb begin
      fwd_a = FW'(FWD_REGFILE);
      fwd_b = FW'(FWD_REGFILE);
      if (FWD_EN != 0 && entries[0].valid) begin
         for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (fhit_rs[k]) fwd_a = FW'(k);
            if (fhit_rt[k]) fwd_b = FW'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (stall && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign bus.stall       = stall;
   assign bus.bubble      = stall || bus.flush;
   assign bus.fwd_a       = fwd_a;
   assign bus.fwd_b       = fwd_b;
   assign bus.stall_count = count;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard bench: three scoreboard variants share one ID stimulus stream;
// expected outputs are queued per cycle and checked by a negedge monitor.
module tb_pipe_hazard_scoreboard;

   typedef struct {
      int          dut;
      string       name;
      logic        stall;
      logic        bubble;
      logic [1:0]  fwd_a;
      logic [1:0]  fwd_b;
      int unsigned count;
   } expect_t;

   expect_t expQ[$];
   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

   pipe_hazard_scoreboard_if #(.NSTAGE(3), .RAW(5), .CNTW(32)) busD ();
   pipe_hazard_scoreboard_if #(.NSTAGE(3), .RAW(5), .CNTW(32)) busN ();
   pipe_hazard_scoreboard_if #(.NSTAGE(3), .RAW(5), .CNTW(2))  busL ();

   assign busD.id_valid = id_valid;         assign busN.id_valid = id_valid;         assign busL.id_valid = id_valid;
   assign busD.id_rs = id_rs;               assign busN.id_rs = id_rs;               assign busL.id_rs = id_rs;
   assign busD.id_rt = id_rt;               assign busN.id_rt = id_rt;               assign busL.id_rt = id_rt;
   assign busD.id_use_rs = id_use_rs;       assign busN.id_use_rs = id_use_rs;       assign busL.id_use_rs = id_use_rs;
   assign busD.id_use_rt = id_use_rt;       assign busN.id_use_rt = id_use_rt;       assign busL.id_use_rt = id_use_rt;
   assign busD.id_rd = id_rd;               assign busN.id_rd = id_rd;               assign busL.id_rd = id_rd;
   assign busD.id_reg_write = id_reg_write; assign busN.id_reg_write = id_reg_write; assign busL.id_reg_write = id_reg_write;
   assign busD.id_mem_read = id_mem_read;   assign busN.id_mem_read = id_mem_read;   assign busL.id_mem_read = id_mem_read;
   assign busD.flush = flush;               assign busN.flush = flush;               assign busL.flush = flush;

   pipe_hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(1), .ALU_LAT(0), .FWD_EN(1), .CNTW(32))
      dutD (.clk(clk), .rst(rst), .bus(busD));
   pipe_hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(1), .ALU_LAT(0), .FWD_EN(0), .CNTW(32))
      dutN (.clk(clk), .rst(rst), .bus(busN));
   pipe_hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(2), .ALU_LAT(0), .FWD_EN(1), .CNTW(2))
      dutL (.clk(clk), .rst(rst), .bus(busL));

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urs, input logic urt,
                                input logic rw, input logic mr);
      id_valid = v; id_rd = rd; id_rs = rs; id_rt = rt;
      id_use_rs = urs; id_use_rt = urt; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      applyStimulus(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic lw(input logic [4:0] rd, input logic [4:0] base);
      applyStimulus(1'b1, rd, base, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expectOut(input int dut, input string name, input logic st, input logic bb,
                            input logic [1:0] fa, input logic [1:0] fb, input int unsigned cnt);
      expect_t e;
      e.dut = dut; e.name = name; e.stall = st; e.bubble = bb;
      e.fwd_a = fa; e.fwd_b = fb; e.count = cnt;
      expQ.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; flush = 1'b0; idle();
      step(); step();
      rst = 1'b0;
   endtask

   task automatic checkOutput(input expect_t e);
      logic a_st, a_bb;
      logic [1:0] a_fa, a_fb;
      int unsigned a_cnt;
      case (e.dut)
         0: begin a_st = busD.stall; a_bb = busD.bubble; a_fa = busD.fwd_a; a_fb = busD.fwd_b; a_cnt = busD.stall_count; end
         1: begin a_st = busN.stall; a_bb = busN.bubble; a_fa = busN.fwd_a; a_fb = busN.fwd_b; a_cnt = busN.stall_count; end
         default: begin a_st = busL.stall; a_bb = busL.bubble; a_fa = busL.fwd_a; a_fb = busL.fwd_b; a_cnt = {30'd0, busL.stall_count}; end
      endcase
      checks++;
      if (a_st !== e.stall || a_bb !== e.bubble || a_fa !== e.fwd_a || a_fb !== e.fwd_b || a_cnt != e.count) begin
         errors++;
         $display("[TB] FAIL %s: got stall=%0b bubble=%0b fwd_a=%0d fwd_b=%0d count=%0d, want stall=%0b bubble=%0b fwd_a=%0d fwd_b=%0d count=%0d",
                  e.name, a_st, a_bb, a_fa, a_fb, a_cnt, e.stall, e.bubble, e.fwd_a, e.fwd_b, e.count);
      end
   endtask

   always @(negedge clk) begin
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Load-use: one stall cycle, then forward from the WB bus
      doReset();
      lw(5'd2, 5'd1);             expectOut(0, "reset_state",     0, 0, 0, 0, 0); step();
      alu(5'd3, 5'd2, 5'd4);      expectOut(0, "load_use_stall",  1, 1, 0, 0, 0); step();
      alu(5'd3, 5'd2, 5'd4);      expectOut(0, "load_use_clear",  0, 0, 0, 0, 1); step();
      idle();                     expectOut(0, "load_use_fwd_wb", 0, 0, 2, 0, 1); step();

      // ALU back-to-back: no stall, forward from MEM on both operands
      doReset();
      alu(5'd2, 5'd1, 5'd1);      step();
      alu(5'd5, 5'd2, 5'd2);      expectOut(0, "alu_b2b_nostall", 0, 0, 0, 0, 0); step();
      idle();                     expectOut(0, "alu_b2b_fwd_mem", 0, 0, 1, 1, 0); step();

      // Two producers of $2: youngest wins; $0 operand never forwards
      doReset();
      alu(5'd2, 5'd1, 5'd1);      step();
      alu(5'd2, 5'd3, 5'd3);      step();
      alu(5'd6, 5'd2, 5'd0);      expectOut(0, "youngest_nostall", 0, 0, 0, 0, 0); step();
      idle();                     expectOut(0, "youngest_fwd",     0, 0, 1, 0, 0); step();

      // Forwarding disabled: two-cycle stall until producer reaches WB
      doReset();
      alu(5'd7, 5'd1, 5'd1);      expectOut(1, "nofwd_reset",   0, 0, 0, 0, 0); step();
      alu(5'd8, 5'd7, 5'd7);      expectOut(1, "nofwd_stall1",  1, 1, 0, 0, 0); step();
      alu(5'd8, 5'd7, 5'd7);      expectOut(1, "nofwd_stall2",  1, 1, 0, 0, 1); step();
      alu(5'd8, 5'd7, 5'd7);      expectOut(1, "nofwd_release", 0, 0, 0, 0, 2); step();
      idle();                     expectOut(1, "nofwd_no_fwd",  0, 0, 0, 0, 2); step();

      // Flush overrides a load-use stall; the squashed load never enters EX
      doReset();
      lw(5'd2, 5'd1);             step();
      lw(5'd5, 5'd2); flush = 1;  expectOut(0, "flush_cycle",   0, 1, 0, 0, 0); step();
      flush = 0;
      alu(5'd6, 5'd5, 5'd5);      expectOut(0, "flush_squashed", 0, 0, 0, 0, 0); step();
      idle();                     expectOut(0, "flush_after",   0, 0, 0, 0, 0); step();

      // Register 0 is never a hazard or forward source
      doReset();
      lw(5'd0, 5'd1);             step();
      alu(5'd9, 5'd0, 5'd0);      expectOut(0, "reg0_nostall", 0, 0, 0, 0, 0); step();
      idle();                     expectOut(0, "reg0_nofwd",   0, 0, 0, 0, 0); step();

      // LOAD_LAT=2 with a 2-bit counter: saturation at 3
      doReset();
      lw(5'd2, 5'd1);             step();
      lw(5'd2, 5'd2);             expectOut(2, "lat2_stall_a", 1, 1, 0, 0, 0); step();
      lw(5'd2, 5'd2);             expectOut(2, "lat2_stall_b", 1, 1, 0, 0, 1); step();
      lw(5'd2, 5'd2);             expectOut(2, "lat2_release", 0, 0, 0, 0, 2); step();
      lw(5'd2, 5'd2);             expectOut(2, "lat2_stall_c", 1, 1, 0, 0, 2); step();
      lw(5'd2, 5'd2);             expectOut(2, "lat2_stall_d", 1, 1, 0, 0, 3); step();
      idle();                     expectOut(2, "cnt_saturated", 0, 0, 0, 0, 3); step();

      // Reset in the middle of a multi-cycle stall drops all in-flight tags
      doReset();
      lw(5'd2, 5'd1);             step();
      alu(5'd3, 5'd2, 5'd2);      expectOut(2, "pre_reset_stall", 1, 1, 0, 0, 0); step();
      rst = 1;                    expectOut(2, "reset_asserted",  1, 1, 0, 0, 1); step();
      rst = 0;                    expectOut(2, "post_reset",      0, 0, 0, 0, 0); step();
      idle();                     step();
      step();

      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected entries left unchecked, want 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
Parametrised successor to the fixed 5-stage hazard-detection and forwarding pair in the MIPS pipeline core. It tracks a destination-register tag for every post-decode stage in a shift register, and drives three things: the PC/IF-ID hold, bubble insertion and per-operand forwarding selects. Stage count, load latency and forwarding enable are generic. It adds branch-flush squash and a stall performance counter, which the fixed units lack. It sits beside the ID stage and replaces the separate hazard and forward units.

Parameters:
NSTAGE, 3, number of tracked post-ID stages (0=EX, 1=MEM, 2=WB, ...); legal range 2..8
RAW, 5, register address width
LOAD_LAT, 1, index of the stage at whose end load data exists (1 = MEM)
ALU_LAT, 0, index of the stage at whose end ALU data exists (0 = EX)
FWD_EN, 1, 1 = forwarding enabled; 0 = stall until producer reaches last stage (write-before-read regfile)
CNTW, 32, stall counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  RAW  ID source register 1
id_rt  in  RAW  ID source register 2
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_rd  in  RAW  ID destination (post reg_dst mux)
id_reg_write  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
flush  in  1  taken branch/jump: squash ID and EX
stall  out  1  hold PC and IF/ID (pc_write = if_id_write = !stall)
bubble  out  1  zero ID/EX control (stall | flush)
fwd_a  out  $clog2(NSTAGE)  EX rs source: 0=ID/EX latch, k=result bus of stage k
fwd_b  out  $clog2(NSTAGE)  EX rt source, same encoding
stall_count  out  CNTW  saturating count of stall cycles

Behaviour:
- Entry per stage: valid, rd, reg_write, ready_stage (LOAD_LAT if load, else ALU_LAT), rs, rt, use_rs, use_rt. Stage 0 is the EX entry.
- Every clk, entries shift k -> k+1; the entry in stage NSTAGE-1 is dropped.
- Stage 0 receives the ID entry when id_valid & !stall & !flush; otherwise it receives an invalid bubble.
- Producer match for a source s at stage k: valid & reg_write & rd == s & rd != 0 & the matching use_* bit.
- Stall, FWD_EN=1: id_valid & match at some stage k with k < ready_stage of that entry. Default case: a load in EX stalls 1 cycle.
- Stall, FWD_EN=0: id_valid & match at any k <= NSTAGE-2.
- Stall is combinational from current entries and ID inputs, and re-evaluates each cycle. A multi-cycle stall is therefore automatic when LOAD_LAT > 1.
- flush: stage 0 becomes invalid next cycle. The stall output is forced 0 in the flush cycle, because ID is squashed. flush overrides stall; bubble = 1.
- fwd_a/fwd_b, computed combinationally from the stage-0 entry:
  - Result is the smallest k in 1..NSTAGE-1 whose entry matches stage-0 rs/rt, else 0. The youngest producer wins.
  - fwd_a/fwd_b are 0 when FWD_EN=0 or stage 0 is invalid.
- stall_count: +1 on each clk with stall=1; holds at all-ones.
- Reset (rst=1 at clk edge): all entries invalid, stall_count=0. Consequently stall=0, bubble=0 (absent flush), fwd_a=fwd_b=0 the cycle after reset.
- Reset mid-stall: in-flight tags are discarded with no residual stall.
- Register 0 never causes stall or forwarding.
- Simultaneous match in two stages: forwarding takes the smaller k. Stall considers all matching stages (OR).

Decomposition:
- Package mips_pipe_pkg holds:
  - stage_entry_t struct (valid, rd, reg_write, ready_stage, rs, rt, use_rs, use_rt)
  - FWD_REGFILE = 0 constant
  - default LOAD_LAT/ALU_LAT constants
- One sub-module, pipe_tag_shift: NSTAGE-deep register array of stage_entry_t with load/bubble insert and sync reset.
- Match, stall and forward logic stay in the top as combinational generate loops.

Test Plan:
- Defaults; lw $2 issued, next cycle add $3,$2,$4 -> stall=1 and bubble=1 for exactly 1 cycle; then add enters EX with fwd_a=2 (WB bus); stall_count=1.
- Defaults; add $2,$1,$1 then sub $5,$2,$2 back-to-back -> no stall; sub in EX has fwd_a=fwd_b=1.
- add $2 followed by add $2 again, then or $6,$2,$0 -> or in EX sees fwd_a=1 (youngest), not 2.
- FWD_EN=0, NSTAGE=3; add $7 then and $8,$7,$7 -> stall for 2 cycles; fwd_a=fwd_b=0 throughout; stall_count=2.
- lw $2 in EX, dependent in ID, flush=1 same cycle -> stall=0, bubble=1; next cycle stage 0 invalid; stall_count unchanged.
- Producer writing $0, then consumer of $0 -> no stall, fwd=0. Then assert rst during a LOAD_LAT=2 stall -> next cycle stall=0, stall_count=0.
